cpu_core: RTL and testbench

- Multi-cycle 16-bit accumulator-less CPU; memory-to-memory architecture.
- Connects to an external 64x16 single-port word memory through `mem_addr`/`mem_data`/`mem_we`/`mem_in`.
- Eight general registers R0..R7 are memory words 0..7.
- Reads a 16-bit input port, drives a 16-bit output port and exposes PC and SP for debug.

---
 rtl/cpu_core_if.sv | 25 ++
 rtl/cpu_core.sv | 270 +++++++++++++++++++++++++++
 tb/tb_cpu_core.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_core_if.sv
// Memory bus between cpu_core and an external single-port word memory.
// The memory registers its read data, so mem_in always reflects the address of the previous edge.
interface cpu_core_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
);
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [DATA_WIDTH-1:0] mem_in;

    modport master (
        output mem_we,
        output mem_addr,
        output mem_data,
        input  mem_in
    );

    modport slave (
        input  mem_we,
        input  mem_addr,
        input  mem_data,
        output mem_in
    );
endinterface

// File: rtl/cpu_core.sv
// Multi-cycle memory-to-memory 16-bit CPU; registers R0..R7 live in memory words 0..7.
// Every memory read is an ADDR/WAIT pair, with the data consumed in the state that follows.
module cpu_core #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16,
    parameter int PC_START   = 8,
    parameter int SP_START   = 63
) (
    input  logic                  clk,
    input  logic                  rst,
    cpu_core_if.master            bus,
    input  logic [DATA_WIDTH-1:0] in,
    output logic [DATA_WIDTH-1:0] out,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] sp
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_FETCH_WAIT,
        S_DECODE,
        S_IMM_ADDR,
        S_IMM_WAIT,
        S_IMM_READ,
        S_OP_ADDR,
        S_OP_WAIT,
        S_OP_READ,
        S_OP_WAIT2,
        S_OP_READ2,
        S_EXEC,
        S_HALT
    } state_t;

    typedef enum logic [1:0] {
        SEL_Y,
        SEL_Z,
        SEL_X
    } sel_t;

    localparam logic [3:0] OP_MOV  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_IN   = 4'b0111;
    localparam logic [3:0] OP_OUT  = 4'b1000;
    localparam logic [3:0] OP_STOP = 4'b1111;

    function automatic logic f_imm(input logic [DATA_WIDTH-1:0] w);
        return (w[15:12] == OP_MOV) && (w[3:0] == 4'b1000);
    endfunction

    function automatic logic f_arith(input logic [DATA_WIDTH-1:0] w);
        return (w[15:12] == OP_ADD) || (w[15:12] == OP_SUB) || (w[15:12] == OP_MUL);
    endfunction

    function automatic logic f_writes(input logic [DATA_WIDTH-1:0] w);
        return (w[15:12] == OP_MOV) || f_arith(w) || (w[15:12] == OP_IN);
    endfunction

    function automatic logic f_need_y(input logic [DATA_WIDTH-1:0] w);
        return ((w[15:12] == OP_MOV) && !f_imm(w)) || f_arith(w);
    endfunction

    // X is read as a value for OUT, or as a destination pointer when a writer uses indirect X.
    function automatic logic f_need_x(input logic [DATA_WIDTH-1:0] w);
        return (w[15:12] == OP_OUT) || (w[11] && f_writes(w));
    endfunction

    state_t                state_q, state_d;
    sel_t                  sel_q, sel_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] sp_q, sp_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic [DATA_WIDTH-1:0] op_x_q, op_x_d;
    logic [DATA_WIDTH-1:0] op_y_q, op_y_d;
    logic [DATA_WIDTH-1:0] op_z_q, op_z_d;
    logic [ADDR_WIDTH-1:0] dest_q, dest_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;

    logic [2:0]            field_addr;
    logic                  field_mode;
    state_t                adv_state;
    sel_t                  adv_sel;
    logic [DATA_WIDTH-1:0] result;
    logic [ADDR_WIDTH-1:0] dest_addr;

    always_comb begin
        field_addr = ir_q[10:8];
        field_mode = ir_q[11];
        case (sel_q)
            SEL_Y: begin
                field_addr = ir_q[6:4];
                field_mode = ir_q[7];
            end
            SEL_Z: begin
                field_addr = ir_q[2:0];
                field_mode = ir_q[3];
            end
            default: ;
        endcase
    end

    // Operands are gathered in Y, Z, X order; anything the opcode does not use is skipped.
    always_comb begin
        adv_state = S_EXEC;
        adv_sel   = sel_q;
        if (sel_q == SEL_Y && f_arith(ir_q)) begin
            adv_state = S_OP_ADDR;
            adv_sel   = SEL_Z;
        end else if (sel_q != SEL_X && f_need_x(ir_q)) begin
            adv_state = S_OP_ADDR;
            adv_sel   = SEL_X;
        end
    end

    always_comb begin
        result = op_y_q;
        case (ir_q[15:12])
            OP_ADD:  result = op_y_q + op_z_q;
            OP_SUB:  result = op_y_q - op_z_q;
            OP_MUL:  result = op_y_q * op_z_q;
            OP_IN:   result = in;
            default: ;
        endcase
        dest_addr = ir_q[11] ? dest_q : ADDR_WIDTH'(ir_q[10:8]);
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        pc_d       = pc_q;
        sp_d       = sp_q;
        out_d      = out_q;
        ir_d       = ir_q;
        op_x_d     = op_x_q;
        op_y_d     = op_y_q;
        op_z_d     = op_z_q;
        dest_d     = dest_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        case (state_q)
            S_FETCH: begin
                mem_addr_d = pc_q;
                state_d    = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: state_d = S_DECODE;
            S_DECODE: begin
                ir_d  = bus.mem_in;
                pc_d  = pc_q + ADDR_WIDTH'(1);
                sel_d = SEL_Y;
                if (bus.mem_in[15:12] == OP_STOP) begin
                    state_d = S_HALT;
                end else if (f_imm(bus.mem_in)) begin
                    state_d = S_IMM_ADDR;
                end else if (f_need_y(bus.mem_in)) begin
                    state_d = S_OP_ADDR;
                end else if (f_need_x(bus.mem_in)) begin
                    sel_d   = SEL_X;
                    state_d = S_OP_ADDR;
                end else if (f_writes(bus.mem_in)) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_IMM_ADDR: begin
                mem_addr_d = pc_q;
                state_d    = S_IMM_WAIT;
            end
            S_IMM_WAIT: state_d = S_IMM_READ;
            S_IMM_READ: begin
                op_y_d  = bus.mem_in;
                pc_d    = pc_q + ADDR_WIDTH'(1);
                sel_d   = adv_sel;
                state_d = adv_state;
            end
            S_OP_ADDR: begin
                mem_addr_d = ADDR_WIDTH'(field_addr);
                state_d    = S_OP_WAIT;
            end
            S_OP_WAIT: state_d = S_OP_READ;
            S_OP_READ: begin
                if (field_mode) begin
                    // An indirect destination only needs the pointer, not the word it points to.
                    if (sel_q == SEL_X && f_writes(ir_q)) begin
                        dest_d  = bus.mem_in[ADDR_WIDTH-1:0];
                        state_d = S_EXEC;
                    end else begin
                        mem_addr_d = bus.mem_in[ADDR_WIDTH-1:0];
                        state_d    = S_OP_WAIT2;
                    end
                end else begin
                    case (sel_q)
                        SEL_Y:   op_y_d = bus.mem_in;
                        SEL_Z:   op_z_d = bus.mem_in;
                        default: op_x_d = bus.mem_in;
                    endcase
                    sel_d   = adv_sel;
                    state_d = adv_state;
                end
            end
            S_OP_WAIT2: state_d = S_OP_READ2;
            S_OP_READ2: begin
                case (sel_q)
                    SEL_Y:   op_y_d = bus.mem_in;
                    SEL_Z:   op_z_d = bus.mem_in;
                    default: op_x_d = bus.mem_in;
                endcase
                sel_d   = adv_sel;
                state_d = adv_state;
            end
            S_EXEC: begin
                if (ir_q[15:12] == OP_OUT) begin
                    out_d = op_x_q;
                end else begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = dest_addr;
                    mem_data_d = result;
                end
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            sel_q      <= SEL_Y;
            pc_q       <= ADDR_WIDTH'(PC_START);
            sp_q       <= ADDR_WIDTH'(SP_START);
            out_q      <= '0;
            ir_q       <= '0;
            op_x_q     <= '0;
            op_y_q     <= '0;
            op_z_q     <= '0;
            dest_q     <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            pc_q       <= pc_d;
            sp_q       <= sp_d;
            out_q      <= out_d;
            ir_q       <= ir_d;
            op_x_q     <= op_x_d;
            op_y_q     <= op_y_d;
            op_z_q     <= op_z_d;
            dest_q     <= dest_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_data = mem_data_q;
    assign out          = out_q;
    assign pc           = pc_q;
    assign sp           = sp_q;

endmodule

// File: tb/tb_cpu_core.sv
// Self-checking bench for cpu_core: a behavioural 64x16 memory, a write scoreboard,
// a table of single-instruction arithmetic vectors and hand-written multi-instruction programs.
module tb_cpu_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_port;
    logic [15:0] out_port;
    logic [5:0]  pc;
    logic [5:0]  sp;

    cpu_core_if #(.ADDR_WIDTH(6), .DATA_WIDTH(16)) bus ();

    cpu_core #(
        .ADDR_WIDTH(6),
        .DATA_WIDTH(16),
        .PC_START(8),
        .SP_START(63)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .in  (in_port),
        .out (out_port),
        .pc  (pc),
        .sp  (sp)
    );

    always #5 clk = ~clk;

    // Behavioural memory with registered read; the bench loads or clears it through side ports.
    logic [15:0] mem [64];
    logic        load_en;
    logic        clear_en;
    logic [5:0]  load_addr;
    logic [15:0] load_data;

    always @(posedge clk) begin
        if (clear_en) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else if (load_en) begin
            mem[load_addr] <= load_data;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_data;
        end
        bus.mem_in <= mem[bus.mem_addr];
    end

    typedef struct {
        logic [5:0]  addr;
        logic [15:0] data;
        logic [5:0]  pc;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Every write pulse is matched in order against the expected writes, including the pc it occurs under.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write",
                         bus.mem_addr, bus.mem_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                checkOutput("write_addr", 32'(bus.mem_addr), 32'(e.addr));
                checkOutput("write_data", 32'(bus.mem_data), 32'(e.data));
                checkOutput("write_pc", 32'(pc), 32'(e.pc));
            end
        end
    end

    task automatic applyStimulus();
        @(negedge clk);
        rst      = 1'b1;
        clear_en = 1'b1;
        @(negedge clk);
        clear_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic loadWord(input logic [5:0] a, input logic [15:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    task automatic pushWrite(input logic [5:0] a, input logic [15:0] d, input logic [5:0] p);
        wr_t e;
        e.addr = a;
        e.data = d;
        e.pc   = p;
        exp_q.push_back(e);
    endtask

    task automatic waitPc(input logic [5:0] target, input string name);
        int n = 0;
        while (pc !== target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 32'(pc), 32'(target));
    endtask

    task automatic runToHalt(input logic [5:0] target, input string name);
        waitPc(target, {name, "_reach"});
        repeat (30) @(negedge clk);
        checkOutput({name, "_pc_frozen"}, 32'(pc), 32'(target));
        checkOutput({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    typedef struct {
        logic [15:0] instr;
        logic [15:0] r1;
        logic [15:0] r2;
        logic [15:0] r4;
        logic [15:0] r6;
        logic [5:0]  dest;
        logic [15:0] expv;
        string       name;
    } vec_t;

    vec_t vecs[10];

    initial begin
        rst       = 1'b1;
        in_port   = '0;
        load_en   = 1'b0;
        clear_en  = 1'b0;
        load_addr = '0;
        load_data = '0;

        vecs[0] = '{16'h3312, 16'h8000, 16'h0002, 16'h0000, 16'h0000, 6'd3,  16'h0000, "mul_wrap"};
        vecs[1] = '{16'h2421, 16'h8000, 16'h0002, 16'h0000, 16'h0000, 6'd4,  16'h8002, "sub_wrap"};
        vecs[2] = '{16'h1511, 16'h8000, 16'h0002, 16'h0000, 16'h0000, 6'd5,  16'h0000, "add_wrap"};
        vecs[3] = '{16'h1312, 16'h1234, 16'h1111, 16'h0000, 16'h0000, 6'd3,  16'h2345, "add_basic"};
        vecs[4] = '{16'h2312, 16'h0005, 16'h0007, 16'h0000, 16'h0000, 6'd3,  16'hFFFE, "sub_neg"};
        vecs[5] = '{16'h3312, 16'h0123, 16'h0010, 16'h0000, 16'h0000, 6'd3,  16'h1230, "mul_low"};
        vecs[6] = '{16'h1392, 16'h0006, 16'h0005, 16'h0000, 16'h0100, 6'd3,  16'h0105, "add_ind_y"};
        vecs[7] = '{16'h1C12, 16'h0003, 16'h0004, 16'h0020, 16'h0000, 6'h20, 16'h0007, "add_ind_x"};
        vecs[8] = '{16'h0720, 16'h0000, 16'hBEEF, 16'h0000, 16'h0000, 6'd7,  16'hBEEF, "mov_reg"};
        vecs[9] = '{16'h261A, 16'h0010, 16'h0004, 16'h0003, 16'h0000, 6'd6,  16'h000D, "sub_ind_z"};

        // Reset values after two cycles of reset.
        applyStimulus();
        checkOutput("reset_pc", 32'(pc), 32'd8);
        checkOutput("reset_sp", 32'(sp), 32'd63);
        checkOutput("reset_out", 32'(out_port), 32'd0);
        checkOutput("reset_mem_we", 32'(bus.mem_we), 32'd0);
        checkOutput("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
        checkOutput("reset_mem_data", 32'(bus.mem_data), 32'd0);

        // IN, IN, ADD, OUT, STOP.
        loadWord(6'd8,  16'h7100);
        loadWord(6'd9,  16'h7200);
        loadWord(6'd10, 16'h1312);
        loadWord(6'd11, 16'h8300);
        loadWord(6'd12, 16'hF000);
        pushWrite(6'd1, 16'd8,  6'd9);
        pushWrite(6'd2, 16'd9,  6'd10);
        pushWrite(6'd3, 16'd17, 6'd11);
        in_port = 16'd8;
        rst     = 1'b0;
        waitPc(6'd10, "prog_in2_start");
        in_port = 16'd9;
        runToHalt(6'd13, "prog_add");
        checkOutput("prog_add_mem3", 32'(mem[3]), 32'd17);
        checkOutput("prog_add_out", 32'(out_port), 32'd17);
        checkOutput("prog_add_sp", 32'(sp), 32'd63);

        // Immediate moves and an indirect destination.
        applyStimulus();
        loadWord(6'd8,  16'h0108);
        loadWord(6'd9,  16'h0005);
        loadWord(6'd10, 16'h0208);
        loadWord(6'd11, 16'h1234);
        loadWord(6'd12, 16'h0920);
        loadWord(6'd13, 16'h8500);
        loadWord(6'd14, 16'hF000);
        pushWrite(6'd1, 16'h0005, 6'd10);
        pushWrite(6'd2, 16'h1234, 6'd12);
        pushWrite(6'd5, 16'h1234, 6'd13);
        rst = 1'b0;
        runToHalt(6'd15, "prog_imm");
        checkOutput("prog_imm_mem5", 32'(mem[5]), 32'h1234);
        checkOutput("prog_imm_out", 32'(out_port), 32'h1234);

        // Single-instruction vectors followed by STOP.
        for (int v = 0; v < 10; v++) begin
            applyStimulus();
            loadWord(6'd1, vecs[v].r1);
            loadWord(6'd2, vecs[v].r2);
            loadWord(6'd4, vecs[v].r4);
            loadWord(6'd6, vecs[v].r6);
            loadWord(6'd8, vecs[v].instr);
            loadWord(6'd9, 16'hF000);
            pushWrite(vecs[v].dest, vecs[v].expv, 6'd9);
            rst = 1'b0;
            runToHalt(6'd10, vecs[v].name);
            checkOutput({vecs[v].name, "_mem"}, 32'(mem[vecs[v].dest]), 32'(vecs[v].expv));
        end

        // Reset during the Y operand wait of an ADD, then a clean rerun.
        applyStimulus();
        loadWord(6'd1, 16'd1);
        loadWord(6'd2, 16'd2);
        loadWord(6'd8, 16'h1312);
        loadWord(6'd9, 16'hF000);
        rst = 1'b0;
        begin
            int n = 0;
            while (bus.mem_addr !== 6'd1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            checkOutput("midrst_reached_wait", 32'(bus.mem_addr), 32'd1);
        end
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_pc", 32'(pc), 32'd8);
        checkOutput("midrst_mem_we", 32'(bus.mem_we), 32'd0);
        checkOutput("midrst_mem3", 32'(mem[3]), 32'd0);
        pushWrite(6'd3, 16'd3, 6'd9);
        rst = 1'b0;
        runToHalt(6'd10, "midrst_rerun");
        checkOutput("midrst_rerun_mem3", 32'(mem[3]), 32'd3);

        // OUT, then DIV and an unassigned opcode behaving as NOPs.
        applyStimulus();
        loadWord(6'd1,  16'h00AA);
        loadWord(6'd2,  16'h0003);
        loadWord(6'd8,  16'h8100);
        loadWord(6'd9,  16'h4312);
        loadWord(6'd10, 16'h5000);
        loadWord(6'd11, 16'hF000);
        rst = 1'b0;
        waitPc(6'd10, "nop_div_step");
        waitPc(6'd11, "nop_5000_step");
        runToHalt(6'd12, "nop_prog");
        checkOutput("nop_out", 32'(out_port), 32'h00AA);
        checkOutput("nop_mem3", 32'(mem[3]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
